decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 206 ++++++++++++++++++++
 tb/tb_decode_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
//   Instruction decode pipeline stage with a valid/ready handshake on both
//   sides. Holds up to two instructions: an output register and a one-entry
//   skid buffer. The skid buffer lets in_ready_o come straight from a flop
//   instead of depending combinationally on out_ready_i. Each instruction is
//   decoded when it is captured:
//     - the immediate is selected by opcode;
//     - the exception (fetch fault, misaligned pc or illegal opcode) is
//       computed and stored with the instruction.
//
// Parameters
//   XLEN : datapath width, 32 or 64.
//   RV64 : 1 enables the OPIMM32/OP32 opcodes; set to 1 exactly when XLEN=64.
//
// Ports
//   clk_i, rst_i       clock, asynchronous active-high reset
//   flush_i            drop both held instructions (and any offered one)
//   in_valid_i/in_ready_o, in_instr_i, in_pc_i, in_fault_i
//                      fetch-side handshake and payload
//   out_valid_o/out_ready_i
//                      downstream handshake
//   out_pc_o, out_opcode_o, out_rd_o, out_rs1_o, out_rs2_o,
//   out_funct3_o, out_funct7_o, out_imm_o
//                      decoded fields
//   out_ex_o, out_cause_o, out_tval_o
//                      exception attached to the presented instruction
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int XLEN = 64,
    parameter bit RV64 = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    input  logic            in_fault_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_pc_o,
    output logic [6:0]      out_opcode_o,
    output logic [4:0]      out_rd_o,
    output logic [4:0]      out_rs1_o,
    output logic [4:0]      out_rs2_o,
    output logic [2:0]      out_funct3_o,
    output logic [6:0]      out_funct7_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic            out_ex_o,
    output logic [XLEN-1:0] out_cause_o,
    output logic [XLEN-1:0] out_tval_o
);

    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_MISCMEM = 7'b0001111;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_OP32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

    // Raw instruction is kept so the register fields can be sliced at the
    // output; immediate and exception are resolved once at capture.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic [XLEN-1:0] imm;
        logic            ex;
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
    } entry_t;

    entry_t dec_next;
    entry_t out_reg;
    entry_t skid_reg;
    logic   out_valid_reg;
    logic   skid_empty_reg;

    logic [31:0] imm32;
    logic        legal;
    logic [6:0]  op;

    // ------------------------------------------------------------------
    // Decode of the offered instruction
    // ------------------------------------------------------------------
    assign op = in_instr_i[6:0];

    always_comb begin
        imm32 = '0;
        legal = 1'b0;
        case (op)
            OP_LOAD, OP_OPIMM, OP_JALR, OP_SYSTEM, OP_MISCMEM: begin
                imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
                legal = 1'b1;
            end
            OP_OPIMM32: begin
                imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:20]};
                legal = RV64;
            end
            OP_STORE: begin
                imm32 = {{20{in_instr_i[31]}}, in_instr_i[31:25], in_instr_i[11:7]};
                legal = 1'b1;
            end
            OP_BRANCH: begin
                imm32 = {{20{in_instr_i[31]}}, in_instr_i[7], in_instr_i[30:25],
                         in_instr_i[11:8], 1'b0};
                legal = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                imm32 = {in_instr_i[31:12], 12'b0};
                legal = 1'b1;
            end
            OP_JAL: begin
                imm32 = {{12{in_instr_i[31]}}, in_instr_i[19:12], in_instr_i[20],
                         in_instr_i[30:21], 1'b0};
                legal = 1'b1;
            end
            OP_OP: legal = 1'b1;
            OP_OP32: legal = RV64;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_next       = '0;
        dec_next.pc    = in_pc_i;
        dec_next.instr = in_instr_i;
        // Every immediate is already sign-extended to 32 bits; bit 31 carries
        // instruction bit 31 (or zero for the no-immediate formats), so
        // replicating it widens correctly for either XLEN.
        dec_next.imm   = {{(XLEN-31){imm32[31]}}, imm32[30:0]};
        if (in_fault_i) begin
            dec_next.ex         = 1'b1;
            dec_next.cause[1:0] = 2'd1;
            dec_next.tval       = in_pc_i;
        end else if (in_pc_i[1:0] != 2'b00) begin
            dec_next.ex         = 1'b1;
            dec_next.tval       = in_pc_i;
        end else if (!legal) begin
            dec_next.ex          = 1'b1;
            dec_next.cause[1:0]  = 2'd2;
            dec_next.tval[31:0]  = in_instr_i;
        end
    end

    // ------------------------------------------------------------------
    // Output register + skid buffer
    // ------------------------------------------------------------------
    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & skid_empty_reg;
    assign out_fire = out_valid_reg & out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_reg  <= 1'b0;
            out_reg        <= '0;
            skid_empty_reg <= 1'b1;
            skid_reg       <= '0;
        end else if (flush_i) begin
            out_valid_reg  <= 1'b0;
            skid_empty_reg <= 1'b1;
        end else if (out_fire || !out_valid_reg) begin
            // Output slot frees up: skid entry is older, so it goes first.
            // While the skid is full in_ready is low, so nothing new arrives.
            if (!skid_empty_reg) begin
                out_reg        <= skid_reg;
                out_valid_reg  <= 1'b1;
                skid_empty_reg <= 1'b1;
            end else if (in_fire) begin
                out_reg       <= dec_next;
                out_valid_reg <= 1'b1;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end else if (in_fire) begin
            // Output stalled: park the new instruction in the skid buffer.
            skid_reg       <= dec_next;
            skid_empty_reg <= 1'b0;
        end
    end

    assign in_ready_o   = skid_empty_reg;
    assign out_valid_o  = out_valid_reg;
    assign out_pc_o     = out_reg.pc;
    assign out_opcode_o = out_reg.instr[6:0];
    assign out_rd_o     = out_reg.instr[11:7];
    assign out_funct3_o = out_reg.instr[14:12];
    assign out_rs1_o    = out_reg.instr[19:15];
    assign out_rs2_o    = out_reg.instr[24:20];
    assign out_funct7_o = out_reg.instr[31:25];
    assign out_imm_o    = out_reg.imm;
    assign out_ex_o     = out_reg.ex;
    assign out_cause_o  = out_reg.cause;
    assign out_tval_o   = out_reg.tval;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
//   Scoreboard bench for decode_stage (XLEN=64). Directed vectors carry
//   hand-computed immediates and exceptions. An acceptor process pushes the
//   expected entry on every input transfer; a monitor pops and compares on
//   every output transfer.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int X = 64;

    typedef struct {
        logic [31:0]  instr;
        logic [X-1:0] pc;
        logic         fault;
        logic [X-1:0] imm;
        logic         ex;
        logic [X-1:0] cause;
        logic [X-1:0] tval;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_instr = '0;
    logic [X-1:0] in_pc = '0;
    logic         in_fault = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [X-1:0] out_pc;
    logic [6:0]   out_opcode;
    logic [4:0]   out_rd;
    logic [4:0]   out_rs1;
    logic [4:0]   out_rs2;
    logic [2:0]   out_funct3;
    logic [6:0]   out_funct7;
    logic [X-1:0] out_imm;
    logic         out_ex;
    logic [X-1:0] out_cause;
    logic [X-1:0] out_tval;

    decode_stage #(.XLEN(X), .RV64(1'b1)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_instr_i   (in_instr),
        .in_pc_i      (in_pc),
        .in_fault_i   (in_fault),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_pc_o     (out_pc),
        .out_opcode_o (out_opcode),
        .out_rd_o     (out_rd),
        .out_rs1_o    (out_rs1),
        .out_rs2_o    (out_rs2),
        .out_funct3_o (out_funct3),
        .out_funct7_o (out_funct7),
        .out_imm_o    (out_imm),
        .out_ex_o     (out_ex),
        .out_cause_o  (out_cause),
        .out_tval_o   (out_tval)
    );

    always #5 clk = ~clk;

    int   n_total = 0;
    int   n_bad = 0;
    int   n_delivered = 0;
    vec_t exp_q[$];
    vec_t exp_cur;
    vec_t vecs[14];

    task automatic check(input string name, input logic [X-1:0] got, input logic [X-1:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    // Acceptor: records what the stage has taken in.
    always @(negedge clk) begin
        if (rst || flush)
            exp_q.delete();
        else if (in_valid && in_ready)
            exp_q.push_back(exp_cur);
    end

    // Monitor: compares every output transfer with the oldest expectation.
    always @(negedge clk) begin
        vec_t e;
        if (!rst && !flush && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                n_bad++;
                $display("FAIL unexpected_out: got pc=%h want no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                n_delivered++;
                check("pc",     out_pc, e.pc);
                check("opcode", X'(out_opcode), X'(e.instr[6:0]));
                check("rd",     X'(out_rd),     X'(e.instr[11:7]));
                check("funct3", X'(out_funct3), X'(e.instr[14:12]));
                check("rs1",    X'(out_rs1),    X'(e.instr[19:15]));
                check("rs2",    X'(out_rs2),    X'(e.instr[24:20]));
                check("funct7", X'(out_funct7), X'(e.instr[31:25]));
                check("imm",    out_imm, e.imm);
                check("ex",     X'(out_ex), X'(e.ex));
                check("cause",  out_cause, e.cause);
                check("tval",   out_tval, e.tval);
                $display("txn instr=%h pc=%h imm=%h ex=%0d cause=%0d tval=%h",
                         e.instr, out_pc, out_imm, out_ex, out_cause, out_tval);
            end
        end
    end

    // Offer one instruction and hold it until it is accepted.
    task automatic send(input vec_t v);
        logic acc;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        in_fault = v.fault;
        exp_cur  = v;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            n_bad++;
            $display("FAIL send_timeout: got in_ready=0 want accept of %h", v.instr);
        end
        in_valid = 1'b0;
    endtask

    task automatic offer(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = v.pc;
        in_fault = v.fault;
        exp_cur  = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, X'(out_valid), '0);
        check({tag, "_in_ready"},  X'(in_ready),  X'(1));
        check({tag, "_out_ex"},    X'(out_ex),    '0);
        check({tag, "_out_pc"},    out_pc,        '0);
        check({tag, "_out_imm"},   out_imm,       '0);
        check({tag, "_out_cause"}, out_cause,     '0);
        check({tag, "_out_tval"},  out_tval,      '0);
        check({tag, "_out_rd"},    X'(out_rd),    '0);
    endtask

    initial begin
        logic acc;
        int   n_before;
        //                instr         pc                      flt  imm                      ex   cause    tval
        vecs[0]  = '{32'hFFF00093, 64'h0000_0000_8000_0000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'd0, 64'h0};
        vecs[1]  = '{32'h0040006F, 64'h1000, 1'b0, 64'd4,                  1'b0, 64'd0, 64'h0};
        vecs[2]  = '{32'hFE000EE3, 64'h1004, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'd0, 64'h0};
        vecs[3]  = '{32'h00112423, 64'h1008, 1'b0, 64'd8,                  1'b0, 64'd0, 64'h0};
        vecs[4]  = '{32'h800000B7, 64'h100C, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 64'd0, 64'h0};
        vecs[5]  = '{32'h00000000, 64'h1010, 1'b0, 64'd0,                  1'b1, 64'd2, 64'h0};
        vecs[6]  = '{32'h00000000, 64'h1002, 1'b1, 64'd0,                  1'b1, 64'd1, 64'h1002};
        vecs[7]  = '{32'h00000000, 64'h1002, 1'b0, 64'd0,                  1'b1, 64'd0, 64'h1002};
        vecs[8]  = '{32'h0000000B, 64'h1014, 1'b0, 64'd0,                  1'b1, 64'd2, 64'h0B};
        vecs[9]  = '{32'h002080BB, 64'h1018, 1'b0, 64'd0,                  1'b0, 64'd0, 64'h0};
        vecs[10] = '{32'h00001517, 64'h101C, 1'b0, 64'h1000,               1'b0, 64'd0, 64'h0};
        vecs[11] = '{32'h00000073, 64'h1020, 1'b0, 64'd0,                  1'b0, 64'd0, 64'h0};
        vecs[12] = '{32'h00000091, 64'h1024, 1'b0, 64'd0,                  1'b1, 64'd2, 64'h91};
        vecs[13] = '{32'hFF80B083, 64'h2001, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1, 64'd1, 64'h2001};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Streaming with out_ready high; ADDI first checks one-cycle latency
        out_ready = 1'b1;
        send(vecs[0]);
        check("latency_valid", X'(out_valid), X'(1));
        check("latency_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 1; i < 14; i++)
            send(vecs[i]);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: A in output, B in skid, C refused
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        check("bp_in_ready_low", X'(in_ready), '0);
        check("bp_a_held", out_pc, vecs[1].pc);
        offer(vecs[3]);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_c_refused", X'(in_ready), '0);
            check("bp_a_stable", X'(out_instr_word()), X'(vecs[1].instr));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_no_gap", X'(out_valid), X'(1));
            acc = in_valid & in_ready;
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        check("bp_drained", X'(out_valid), '0);
        check("bp_in_valid_done", X'(in_valid), '0);

        // Flush with both entries full and an instruction offered
        out_ready = 1'b0;
        send(vecs[4]);
        send(vecs[5]);
        offer(vecs[6]);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", X'(out_valid), '0);
        check("flush_in_ready", X'(in_ready), X'(1));
        n_before  = n_delivered;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_nothing_delivered", X'(n_delivered), X'(n_before));

        // Short asynchronous reset pulse between edges with two entries held
        out_ready = 1'b0;
        send(vecs[7]);
        send(vecs[8]);
        check("ar_two_held", X'(in_ready), '0);
        #1 rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b1;
        send(vecs[0]);
        check("post_reset_latency", X'(out_valid), X'(1));

        for (int k = 0; k < 20 && exp_q.size() != 0; k++)
            @(posedge clk);
        #1;
        check("queue_drained", X'(exp_q.size()), '0);
        check("delivered_count", X'(n_delivered), X'(18));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    function automatic logic [31:0] out_instr_word();
        return {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode};
    endfunction

endmodule
